// File: rtl/timer_ctrl.sv
// Countdown-timer control FSM: preset editing, start/pause/resume, alarm expiry.
// All outputs are registered; the timer datapath lives outside this block.
module timer_ctrl #(
  parameter int ALARM_TICKS = 10,
  parameter int MAX_VAL     = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btnMode,
  input  logic       btnInc,
  input  logic       btnStart,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [5:0] minSet,
  output logic [5:0] secSet,
  output logic       set,
  output logic       run,
  output logic       alarm,
  output logic       blinkMin,
  output logic       blinkSec,
  output logic [2:0] state
);

  localparam int CW = $clog2(ALARM_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_MIN = 3'd1,
    SET_SEC = 3'd2,
    RUN     = 3'd3,
    PAUSE   = 3'd4,
    ALARM   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    min_set_q, min_set_d;
  logic [5:0]    sec_set_q, sec_set_d;
  logic          set_q, set_d;
  logic          run_q, run_d;
  logic          alarm_q, alarm_d;
  logic          blink_min_q, blink_min_d;
  logic          blink_sec_q, blink_sec_d;
  logic          phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          any_btn;
  logic          edit_q, edit_d;

  assign cnt_inc = cnt_q + CW'(1);
  assign any_btn = btnStart | btnMode | btnInc;

  always_comb begin
    state_d   = state_q;
    min_set_d = min_set_q;
    sec_set_d = sec_set_q;
    set_d     = 1'b0;
    cnt_d     = cnt_q;
    phase_d   = phase_q;

    // btnStart outranks btnMode, which outranks btnInc, in every state.
    case (state_q)
      IDLE: begin
        if (btnStart) begin
          if ((min_set_q != 6'd0) || (sec_set_q != 6'd0)) begin
            state_d = RUN;
            set_d   = 1'b1;
          end
        end else if (btnMode) begin
          state_d = SET_MIN;
        end
      end
      SET_MIN: begin
        if (!btnStart) begin
          if (btnMode)     state_d = SET_SEC;
          else if (btnInc) min_set_d = (min_set_q >= 6'(MAX_VAL)) ? 6'd0 : min_set_q + 6'd1;
        end
      end
      SET_SEC: begin
        if (!btnStart) begin
          if (btnMode)     state_d = IDLE;
          else if (btnInc) sec_set_d = (sec_set_q >= 6'(MAX_VAL)) ? 6'd0 : sec_set_q + 6'd1;
        end
      end
      RUN: begin
        // The timer only loads on the set edge, so min/sec are stale while set_q is high.
        if (btnStart)                                        state_d = PAUSE;
        else if (!set_q && (min == 6'd0) && (sec == 6'd0))   state_d = ALARM;
      end
      PAUSE: begin
        if (btnStart)     state_d = RUN;
        else if (btnMode) state_d = IDLE;
      end
      ALARM: begin
        if (any_btn) begin
          state_d = IDLE;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(ALARM_TICKS)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == ALARM) && (state_q != ALARM)) cnt_d = '0;

    edit_q = (state_q == SET_MIN) || (state_q == SET_SEC);
    edit_d = (state_d == SET_MIN) || (state_d == SET_SEC);
    if (edit_d && (state_d != state_q)) phase_d = 1'b1;
    else if (edit_q && tick)            phase_d = ~phase_q;

    run_d       = (state_d == RUN);
    alarm_d     = (state_d == ALARM);
    blink_min_d = (state_d == SET_MIN) && phase_d;
    blink_sec_d = (state_d == SET_SEC) && phase_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      min_set_q   <= '0;
      sec_set_q   <= '0;
      set_q       <= 1'b0;
      run_q       <= 1'b0;
      alarm_q     <= 1'b0;
      blink_min_q <= 1'b0;
      blink_sec_q <= 1'b0;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      min_set_q   <= min_set_d;
      sec_set_q   <= sec_set_d;
      set_q       <= set_d;
      run_q       <= run_d;
      alarm_q     <= alarm_d;
      blink_min_q <= blink_min_d;
      blink_sec_q <= blink_sec_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
    end
  end

  assign minSet   = min_set_q;
  assign secSet   = sec_set_q;
  assign set      = set_q;
  assign run      = run_q;
  assign alarm    = alarm_q;
  assign blinkMin = blink_min_q;
  assign blinkSec = blink_sec_q;
  assign state    = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: directed scenarios plus random button/tick traffic,
// checked every cycle against a behavioural model, with extra constant spot checks.
module tb_timer_ctrl;
  localparam int AT = 10;
  localparam int MV = 59;
  localparam int S_IDLE = 0, S_SMIN = 1, S_SSEC = 2, S_RUN = 3, S_PAUSE = 4, S_ALARM = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0, tick = 1'b0, btnMode = 1'b0, btnInc = 1'b0, btnStart = 1'b0;
  logic [5:0] min = 6'd0, sec = 6'd0;
  logic [5:0] minSet, secSet;
  logic       set, run, alarm, blinkMin, blinkSec;
  logic [2:0] state;

  timer_ctrl #(.ALARM_TICKS(AT), .MAX_VAL(MV)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btnMode(btnMode), .btnInc(btnInc),
    .btnStart(btnStart), .min(min), .sec(sec), .minSet(minSet), .secSet(secSet),
    .set(set), .run(run), .alarm(alarm), .blinkMin(blinkMin), .blinkSec(blinkSec),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] ms;
    logic [5:0] ss;
    logic       set;
    logic       run;
    logic       alarm;
    logic       bmin;
    logic       bsec;
  } out_t;

  out_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   d_min = 1, d_sec = 5;

  // Reference model: plain integers following the mode rules.
  int m_st = 0, m_ms = 0, m_ss = 0, m_ph = 0, m_cnt = 0;
  bit m_set = 0;

  task automatic model(input bit r, input bit t, input bit bm, input bit bi, input bit bs,
                       input int mn, input int sc);
    int   nx;
    bit   ns;
    bit   in_edit, to_edit;
    out_t o;
    if (r) begin
      m_st = S_IDLE; m_ms = 0; m_ss = 0; m_ph = 0; m_cnt = 0; m_set = 0;
    end else begin
      nx = m_st;
      ns = 0;
      if (m_st == S_IDLE) begin
        if (bs) begin
          if (m_ms + m_ss > 0) begin nx = S_RUN; ns = 1; end
        end else if (bm) nx = S_SMIN;
      end else if (m_st == S_SMIN) begin
        if (!bs && bm) nx = S_SSEC;
        else if (!bs && bi) m_ms = (m_ms + 1) % (MV + 1);
      end else if (m_st == S_SSEC) begin
        if (!bs && bm) nx = S_IDLE;
        else if (!bs && bi) m_ss = (m_ss + 1) % (MV + 1);
      end else if (m_st == S_RUN) begin
        if (bs) nx = S_PAUSE;
        else if (!m_set && mn == 0 && sc == 0) nx = S_ALARM;
      end else if (m_st == S_PAUSE) begin
        if (bs) nx = S_RUN;
        else if (bm) nx = S_IDLE;
      end else begin
        if (bs || bm || bi) nx = S_IDLE;
        else if (t) begin
          m_cnt++;
          if (m_cnt == AT) nx = S_IDLE;
        end
      end
      if (nx == S_ALARM && m_st != S_ALARM) m_cnt = 0;
      in_edit = (m_st == S_SMIN || m_st == S_SSEC);
      to_edit = (nx == S_SMIN || nx == S_SSEC);
      if (to_edit && nx != m_st) m_ph = 1;
      else if (in_edit && t) m_ph = 1 - m_ph;
      m_st  = nx;
      m_set = ns;
    end
    o.st    = 3'(m_st);
    o.ms    = 6'(m_ms);
    o.ss    = 6'(m_ss);
    o.set   = m_set;
    o.run   = (m_st == S_RUN);
    o.alarm = (m_st == S_ALARM);
    o.bmin  = (m_st == S_SMIN) && (m_ph == 1);
    o.bsec  = (m_st == S_SSEC) && (m_ph == 1);
    exp_q.push_back(o);
  endtask

  // One clock: drive at negedge, predict, return after the edge has settled.
  task automatic cyc(input bit r, input bit t, input bit bm, input bit bi, input bit bs);
    @(negedge clk);
    rst = r; tick = t; btnMode = bm; btnInc = bi; btnStart = bs;
    min = 6'(d_min); sec = 6'(d_sec);
    model(r, t, bm, bi, bs, d_min, d_sec);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  // Monitor: every registered output set is compared once per edge.
  always @(posedge clk) begin : monitor
    out_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, minSet, secSet, set, run, alarm, blinkMin, blinkSec};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL scoreboard @%0t: got st=%0d ms=%0d ss=%0d set=%b run=%b al=%b bm=%b bs=%b expected st=%0d ms=%0d ss=%0d set=%b run=%b al=%b bm=%b bs=%b",
                 $time, a.st, a.ms, a.ss, a.set, a.run, a.alarm, a.bmin, a.bsec,
                 e.st, e.ms, e.ss, e.set, e.run, e.alarm, e.bmin, e.bsec);
      end
    end
  end

  initial begin
    bit bm, bi, bs;
    int dens;
    // Reset, then start with a zero preset does nothing.
    cyc(1, 0, 0, 0, 0);
    chk("rst_state", state, 0); chk("rst_run", run, 0); chk("rst_alarm", alarm, 0);
    chk("rst_minset", minSet, 0);
    cyc(0, 0, 0, 0, 1);
    chk("zero_start_state", state, 0); chk("zero_start_set", set, 0);

    // Edit presets: minutes wrap 59->0 after 61 increments.
    cyc(0, 0, 1, 0, 0);
    chk("enter_setmin", state, 1); chk("blinkmin_entry", blinkMin, 1);
    for (int i = 0; i < 61; i++) cyc(0, (i % 7) == 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("preset_min", minSet, 1); chk("preset_sec", secSet, 5);
    chk("start_set", set, 1); chk("start_state", state, 3); chk("start_run", run, 1);
    cyc(0, 0, 0, 0, 0);
    chk("set_one_cycle", set, 0);

    // Pause and resume.
    cyc(0, 0, 0, 0, 1);
    chk("pause_state", state, 4); chk("pause_run", run, 0);
    cyc(0, 0, 0, 0, 1);
    chk("resume_state", state, 3); chk("resume_run", run, 1); chk("resume_noset", set, 0);

    // Expiry and alarm duration of exactly AT ticks.
    d_min = 0; d_sec = 0;
    cyc(0, 0, 0, 0, 0);
    chk("expire_state", state, 5); chk("expire_run", run, 0); chk("expire_alarm", alarm, 1);
    for (int i = 0; i < AT; i++) begin
      cyc(0, 1, 0, 0, 0);
      if (i == AT - 2) chk("alarm_hold", state, 5);
      if (i == AT - 1) begin chk("alarm_end_state", state, 0); chk("alarm_end_alarm", alarm, 0); end
      cyc(0, 0, 0, 0, 0);
    end

    // Start with stale zero min/sec: no expiry in the set cycle.
    cyc(0, 0, 0, 0, 1);
    chk("restart_set", set, 1);
    cyc(0, 0, 0, 0, 0);
    chk("no_zero_check_on_set", state, 3);
    cyc(0, 0, 0, 0, 0);
    chk("alarm_again", state, 5);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("alarm_btn_exit", state, 0);

    // Priority: start masks inc in SET_MIN.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("prio_minset", minSet, 1); chk("prio_state", state, 1);

    // Reset mid-RUN.
    d_min = 1; d_sec = 5;
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("run_before_rst", run, 1);
    cyc(1, 0, 0, 0, 0);
    chk("midrun_rst_state", state, 0); chk("midrun_rst_run", run, 0);
    chk("midrun_rst_presets", {minSet, secSet}, 0); chk("midrun_rst_set", set, 0);

    // Random traffic: dense buttons first, then sparse so alarms can time out.
    for (int n = 0; n < 4000; n++) begin
      dens = (n < 2000) ? 5 : 40;
      bm = ($urandom_range(0, dens - 1) == 0);
      bi = ($urandom_range(0, dens - 1) == 0) || (n < 2000 && $urandom_range(0, 2) == 0);
      bs = ($urandom_range(0, dens - 1) == 0);
      if ($urandom_range(0, 3) == 0) begin d_min = 0; d_sec = 0; end
      else begin d_min = $urandom_range(0, 59); d_sec = $urandom_range(0, 59); end
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, bm, bi, bs);
    end

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter ALARM_TICKS, default 10: number of tick pulses the alarm stays asserted.
REQ-002 Parameter MAX_VAL, default 59: wrap limit for the minute and second presets.
REQ-003 clk  input  1: single system clock; all logic is clocked on the rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 tick  input  1: one-cycle enable pulse, once per second, from the frequency divider.
REQ-006 btnMode  input  1: one-cycle, already-debounced pulse that steps the mode.
REQ-007 btnInc  input  1: one-cycle, already-debounced pulse that increments the selected field.
REQ-008 btnStart  input  1: one-cycle, already-debounced pulse for start/pause/resume.
REQ-009 min  input  6: current timer minutes, binary 0..59.
REQ-010 sec  input  6: current timer seconds, binary 0..59.
REQ-011 minSet  output  6: registered minute preset driven to the timer.
REQ-012 secSet  output  6: registered second preset driven to the timer.
REQ-013 set  output  1: one-cycle load strobe; the timer loads minSet/secSet on the edge where set=1.
REQ-014 run  output  1: count enable to the timer.
REQ-015 alarm  output  1: expiry indication.
REQ-016 blinkMin  output  1: minute-display blank request while editing minutes.
REQ-017 blinkSec  output  1: second-display blank request while editing seconds.
REQ-018 state  output  3: current FSM state encoding.

Function
REQ-019 FSM states and encodings SHALL be: IDLE=0, SET_MIN=1, SET_SEC=2, RUN=3, PAUSE=4, ALARM=5; codes 6 and 7 SHALL go to IDLE on the next edge.
REQ-020 When buttons coincide in one cycle, priority SHALL be btnStart > btnMode > btnInc; lower-priority buttons are ignored that cycle.
REQ-021 IDLE:
- btnMode -> SET_MIN.
- btnStart with {minSet,secSet} != 0 -> RUN, with set=1 for exactly that one cycle.
- btnStart with a zero preset -> stay in IDLE, no set.
REQ-022 SET_MIN:
- btnInc -> minSet+1, wrapping MAX_VAL -> 0.
- btnMode -> SET_SEC.
- btnStart ignored.
REQ-023 SET_SEC:
- btnInc -> secSet+1, wrapping MAX_VAL -> 0.
- btnMode -> IDLE.
- btnStart ignored.
REQ-024 RUN:
- run=1.
- btnStart -> PAUSE.
- btnMode ignored.
- If min==0 && sec==0 -> ALARM, with run=0 from the next cycle.
- The zero check SHALL NOT occur in the cycle set=1.
REQ-025 PAUSE:
- run=0.
- btnStart -> RUN without set; the count resumes from the held value.
- btnMode -> IDLE.
REQ-026 ALARM:
- alarm=1.
- An internal counter SHALL count tick pulses; on the ALARM_TICKS-th tick -> IDLE.
- Any button pulse -> IDLE on the next edge.
REQ-027 The alarm counter SHALL be cleared on every entry to ALARM.
REQ-028 The blink phase register:
- SHALL be set to 1 on entry to SET_MIN or SET_SEC.
- SHALL toggle on each tick while in those states.
REQ-029 blinkMin SHALL equal (state==SET_MIN && phase); blinkSec SHALL equal (state==SET_SEC && phase); both SHALL be 0 in all other states.
REQ-030 minSet and secSet SHALL change only on btnInc in their own edit state, and SHALL retain their value across RUN, PAUSE and ALARM.
REQ-031 run, alarm, set, blinkMin, blinkSec and state SHALL all be registered, changing only on the clk edge after the causing input.

Reset
REQ-032 When rst=1 at a clk edge, the following SHALL hold next cycle, overriding all other inputs:
- state=IDLE
- minSet=0, secSet=0
- set=0, run=0, alarm=0
- blinkMin=0, blinkSec=0
- phase=0, alarm counter=0
REQ-033 Reset in RUN or ALARM SHALL drop run and alarm to 0 on the next cycle.

Verification
REQ-034 The bench SHALL cover these scenarios:
- Reset, then btnStart -> state stays 0, set never 1.
- btnMode, btnInc x61, btnMode, btnInc x5, btnMode, btnStart -> minSet=1, secSet=5, one set pulse, state=3, run=1.
- In RUN, btnStart -> state=4, run=0; btnStart again -> state=3, run=1, no set pulse.
- In RUN, drive min=0, sec=0 -> next cycle state=5, run=0, alarm=1; after 10 ticks -> state=0, alarm=0.
- In ALARM after 3 ticks, btnInc -> state=0 next cycle; in SET_MIN, btnStart+btnInc same cycle -> minSet unchanged.
- rst asserted mid-RUN -> next cycle all outputs 0, state=0, presets 0.
